// File: rtl/nwc_pointwise_pkg.sv
// Shared types for the negacyclic-convolution pointwise stage:
// operation modes and controller states.
package nwc_pointwise_pkg;

  typedef enum logic [1:0] {
    MODE_MUL = 2'd0,
    MODE_ADD = 2'd1,
    MODE_SUB = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

  // Encoding 2'b11 has no operation of its own and falls back to multiply.
  function automatic mode_e decode_mode(input logic [1:0] m);
    case (m)
      2'd1:    return MODE_ADD;
      2'd2:    return MODE_SUB;
      default: return MODE_MUL;
    endcase
  endfunction

endpackage

// File: rtl/nwc_modmul.sv
// Fixed-latency modular multiplier: (a*b) mod Q by Barrett reduction,
// MUL_LAT registers from operand inputs to result, no handshake.
module nwc_modmul #(
  parameter int DW      = 32,
  parameter int Q       = 786433,
  parameter int MUL_LAT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] p
);

  localparam int K  = $clog2(Q);
  localparam int PW = 2 * DW;
  localparam logic [PW-1:0] ONE = PW'(1);
  localparam logic [PW-1:0] QW  = PW'(Q);
  localparam logic [PW-1:0] MU  = (ONE << (2 * K)) / QW;

  // Quotient estimate undershoots by at most 2, hence two corrections.
  function automatic logic [DW-1:0] barrett(input logic [PW-1:0] x);
    logic [PW-1:0] qe;
    logic [PW-1:0] r;
    qe = ((x >> (K - 1)) * MU) >> (K + 1);
    r  = x - qe * QW;
    if (r >= QW) r = r - QW;
    if (r >= QW) r = r - QW;
    return r[DW-1:0];
  endfunction

  logic [PW-1:0] prod;
  assign prod = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};

  if (MUL_LAT == 1) begin : g_lat1
    always_ff @(posedge clk) begin
      if (rst) p <= '0;
      else     p <= barrett(prod);
    end
  end else begin : g_latn
    localparam int unsigned ND = MUL_LAT - 1;
    logic [PW-1:0] prod_q;
    logic [DW-1:0] dly [ND];

    always_ff @(posedge clk) begin
      if (rst) begin
        prod_q <= '0;
        for (int unsigned i = 0; i < ND; i++) dly[i] <= '0;
      end else begin
        prod_q <= prod;
        dly[0] <= barrett(prod_q);
        for (int unsigned i = 1; i < ND; i++) dly[i] <= dly[i-1];
      end
    end

    assign p = dly[ND-1];
  end

endmodule

// File: rtl/nwc_pointwise.sv
// Pointwise mul/add/sub mod Q over two streamed polynomials, LANES
// coefficients per word, one word per cycle, fixed read-to-write latency.
module nwc_pointwise
  import nwc_pointwise_pkg::*;
#(
  parameter int N       = 4096,
  parameter int LANES   = 2,
  parameter int DW      = 32,
  parameter int Q       = 786433,
  parameter int AW      = 13,
  parameter int RD_LAT  = 1,
  parameter int MUL_LAT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [1:0]          mode,
  output logic [AW-1:0]       addrr,
  input  logic [LANES*DW-1:0] data_in0,
  input  logic [LANES*DW-1:0] data_in1,
  output logic [AW-1:0]       addrw,
  output logic [LANES*DW-1:0] data_out,
  output logic [3:0]          out_wen,
  output logic                done,
  output logic                ready
);

  localparam int          M  = N / LANES;
  localparam int          CW = AW - 2;
  localparam int unsigned L  = RD_LAT + MUL_LAT;
  localparam int unsigned AL = MUL_LAT;
  localparam int          WW = LANES * DW;

  state_e        state, state_nx;
  mode_e         mode_q;
  logic [CW-1:0] cnt;
  logic          run;
  logic          last_rd;

  logic          vld_d  [L];
  logic          last_d [L];
  logic [AW-1:0] adr_d  [L];

  logic [WW-1:0] mul_out;
  logic [WW-1:0] as_res;
  logic [WW-1:0] as_d [AL];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last_rd) state_nx = DRAIN;
      DRAIN:   if (last_d[L-1]) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign run     = (state == RUN);
  assign last_rd = run && (cnt == CW'(M - 1));
  // ready rises together with done, but a new pass is only taken from IDLE.
  assign ready   = (state == IDLE) || (state == DONE);
  assign done    = (state == DONE);
  assign addrr   = run ? {cnt, 2'b00} : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      mode_q <= MODE_MUL;
    end else begin
      if (state == IDLE && start) mode_q <= decode_mode(mode);
      cnt <= run ? cnt + CW'(1) : '0;
    end
  end

  // Valid, last-word and address travel L cycles to line up with data_out.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < L; i++) begin
        vld_d[i]  <= 1'b0;
        last_d[i] <= 1'b0;
        adr_d[i]  <= '0;
      end
    end else begin
      vld_d[0]  <= run;
      last_d[0] <= last_rd;
      adr_d[0]  <= addrr;
      for (int unsigned i = 1; i < L; i++) begin
        vld_d[i]  <= vld_d[i-1];
        last_d[i] <= last_d[i-1];
        adr_d[i]  <= adr_d[i-1];
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [DW-1:0] a, b;
    logic [DW:0]   sum, dif;
    logic [DW-1:0] add_v, sub_v;

    assign a   = data_in0[l*DW +: DW];
    assign b   = data_in1[l*DW +: DW];
    assign sum = {1'b0, a} + {1'b0, b};
    assign dif = {1'b0, a} - {1'b0, b};
    assign add_v = (sum >= (DW+1)'(Q)) ? sum[DW-1:0] - DW'(Q) : sum[DW-1:0];
    assign sub_v = dif[DW] ? dif[DW-1:0] + DW'(Q) : dif[DW-1:0];
    assign as_res[l*DW +: DW] = (mode_q == MODE_SUB) ? sub_v : add_v;

    nwc_modmul #(
      .DW      (DW),
      .Q       (Q),
      .MUL_LAT (MUL_LAT)
    ) u_modmul (
      .clk (clk),
      .rst (rst),
      .a   (a),
      .b   (b),
      .p   (mul_out[l*DW +: DW])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < AL; i++) as_d[i] <= '0;
    end else begin
      as_d[0] <= as_res;
      for (int unsigned i = 1; i < AL; i++) as_d[i] <= as_d[i-1];
    end
  end

  assign data_out = (mode_q == MODE_MUL) ? mul_out : as_d[AL-1];
  assign out_wen  = vld_d[L-1] ? 4'hF : 4'h0;
  assign addrw    = adr_d[L-1];

endmodule
